// File: rtl/arb_req_conditioner.sv
// -----------------------------------------------------------------------------
// arb_req_conditioner
//
// Request conditioning stage in front of the 4-way fixed-priority arbiter
// (priority 1 > 3 > 2 > 0, grants registered one cycle after sampled requests).
// Single-cycle client pulses are accumulated into per-requester pending
// counts. Each requester runs an IDLE/REQ/WAIT cadence so that the arbiter
// sees a request for exactly one cycle per round. This guarantees that one
// grant consumes exactly one pending request.
//
// Optional feature (compile-time macro ARB_STARVE_MON_EN):
//   When defined, a per-requester loss counter flags starvation after
//   STARVE_LIMIT consecutive lost rounds. When undefined, no counters are
//   built and starve is tied to 4'b0000.
//
// Ports
//   arb_clk            in   clock, rising edge
//   arb_rst_n          in   asynchronous active-low reset
//   cli_req[3:0]       in   one-cycle request pulse per client
//   arb_gnt0..3        in   registered grants from the arbiter
//   arb_req0..3        out  level requests to the arbiter (registered)
//   cli_ack[3:0]       out  one-cycle acknowledge per granted request
//   pend_full[3:0]     out  pending count at its maximum
//   drop_err[3:0]      out  sticky: a client pulse was dropped
//   starve[3:0]        out  requester is starving (0 without the macro)
// -----------------------------------------------------------------------------
module arb_req_conditioner #(
    parameter int CNT_W        = 3,
    parameter int STARVE_LIMIT = 8
) (
    input  logic       arb_clk,
    input  logic       arb_rst_n,
    input  logic [3:0] cli_req,
    input  logic       arb_gnt0,
    input  logic       arb_gnt1,
    input  logic       arb_gnt2,
    input  logic       arb_gnt3,
    output logic       arb_req0,
    output logic       arb_req1,
    output logic       arb_req2,
    output logic       arb_req3,
    output logic [3:0] cli_ack,
    output logic [3:0] pend_full,
    output logic [3:0] drop_err,
    output logic [3:0] starve
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    logic [3:0] gnt_vec;
    logic [3:0] req_vec;

    assign gnt_vec  = {arb_gnt3, arb_gnt2, arb_gnt1, arb_gnt0};
    assign arb_req0 = req_vec[0];
    assign arb_req1 = req_vec[1];
    assign arb_req2 = req_vec[2];
    assign arb_req3 = req_vec[3];

    for (genvar i = 0; i < 4; i++) begin : g_req
        state_e           st_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             req_q;
        logic             ack_q;
        logic             drop_q;
        logic             consume;
        logic             accept;

        // A grant only counts while waiting for the answer to our own
        // request; grants in IDLE or REQ are spurious and ignored.
        assign consume = (st_q == ST_WAIT) && gnt_vec[i];

        // At full count a pulse still fits if a grant frees a slot this cycle.
        assign accept  = cli_req[i] && ((cnt_q != CNT_MAX) || consume);

        always_comb begin
            cnt_d = cnt_q;
            if (accept && !consume) begin
                cnt_d = cnt_q + CNT_ONE;
            end else if (consume && !accept) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end

        // Per-requester FSM. req_q mirrors (next state == REQ) so the level
        // request leaves straight from a flop, and REQ is always followed by
        // WAIT, so the request can never be high two cycles in a row.
        always_ff @(posedge arb_clk or negedge arb_rst_n) begin
            if (!arb_rst_n) begin
                st_q   <= ST_IDLE;
                cnt_q  <= '0;
                req_q  <= 1'b0;
                ack_q  <= 1'b0;
                drop_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                ack_q <= consume;
                if (cli_req[i] && !accept) begin
                    drop_q <= 1'b1;
                end
                case (st_q)
                    ST_IDLE: begin
                        if (cnt_d != '0) begin
                            st_q  <= ST_REQ;
                            req_q <= 1'b1;
                        end
                    end
                    ST_REQ: begin
                        st_q  <= ST_WAIT;
                        req_q <= 1'b0;
                    end
                    ST_WAIT: begin
                        if (consume && (cnt_d == '0)) begin
                            st_q  <= ST_IDLE;
                            req_q <= 1'b0;
                        end else begin
                            // Either more work remains or the round was lost.
                            st_q  <= ST_REQ;
                            req_q <= 1'b1;
                        end
                    end
                    default: begin
                        st_q  <= ST_IDLE;
                        req_q <= 1'b0;
                    end
                endcase
            end
        end

        assign req_vec[i]   = req_q;
        assign cli_ack[i]   = ack_q;
        assign drop_err[i]  = drop_q;
        assign pend_full[i] = (cnt_q == CNT_MAX);

`ifdef ARB_STARVE_MON_EN
        localparam int              LOSS_W   = $clog2(STARVE_LIMIT + 1);
        localparam logic [LOSS_W-1:0] LOSS_MAX = LOSS_W'(STARVE_LIMIT);
        localparam logic [LOSS_W-1:0] LOSS_ONE = LOSS_W'(1);

        logic [LOSS_W-1:0] loss_q;
        logic [LOSS_W-1:0] loss_d;
        logic              starve_q;

        // Count consecutive lost rounds; any consumed grant or return to
        // IDLE ends the losing streak.
        always_comb begin
            loss_d = loss_q;
            if ((st_q == ST_IDLE) || consume) begin
                loss_d = '0;
            end else if ((st_q == ST_WAIT) && (loss_q != LOSS_MAX)) begin
                loss_d = loss_q + LOSS_ONE;
            end
        end

        always_ff @(posedge arb_clk or negedge arb_rst_n) begin
            if (!arb_rst_n) begin
                loss_q   <= '0;
                starve_q <= 1'b0;
            end else begin
                loss_q   <= loss_d;
                starve_q <= (loss_d == LOSS_MAX);
            end
        end

        assign starve[i] = starve_q;
`else
        assign starve[i] = 1'b0;
`endif
    end

endmodule
